// File: rtl/point_pkg.sv
// point_pkg: shared types and default sizes for the point dispatcher.
package point_pkg;
  localparam int N_LP_DEF = 4;
  localparam int OBJ_W_DEF = 3;
  localparam int STATUS_W_DEF = 5;
  localparam int LP_W_DEF = $clog2(N_LP_DEF + 1);
  typedef enum logic {S_IDLE, S_ISSUE} disp_state_t;
  typedef struct packed {
    logic [LP_W_DEF-1:0] lp;
    logic [OBJ_W_DEF-1:0] obj;
    logic cmd;
  } point_cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO of point commands; pointers carry an extra wrap bit.
module cmd_fifo
  import point_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  point_cmd_t data_i,
  output point_cmd_t head_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  point_cmd_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q, wr_d, rd_d;
  logic push_ok, pop_ok;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign pop_ok = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o = mem_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = wr_q + (AW+1)'(push_ok);
    rd_d = rd_q + (AW+1)'(pop_ok);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/point_dispatcher.sv
// point_dispatcher: queues point commands and issues them in order as one-hot
// pulses to idle channels, tracking completion, timeouts and sticky errors.
module point_dispatcher
  import point_pkg::*;
#(
  parameter int N_LP = N_LP_DEF,
  parameter int OBJ_W = OBJ_W_DEF,
  parameter int STATUS_W = STATUS_W_DEF,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255,
  parameter int LP_W = $clog2(N_LP + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [LP_W-1:0]          cmd_lp_i,
  input  logic [OBJ_W-1:0]         cmd_obj_i,
  input  logic                     cmd_i,
  output logic [N_LP-1:0]          sel_o,
  output logic [OBJ_W-1:0]         obj_o,
  output logic                     command_o,
  input  logic [N_LP-1:0]          done_i,
  input  logic [N_LP*STATUS_W-1:0] ch_status_i,
  output logic [N_LP*STATUS_W-1:0] status_o,
  output logic [N_LP-1:0]          busy_o,
  output logic                     err_invalid_o,
  output logic [N_LP-1:0]          err_timeout_o,
  input  logic                     err_clr_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  disp_state_t state_q, state_d;
  logic [N_LP-1:0] busy_q, busy_d, err_to_q, err_to_d, to_set, head_oh;
  logic err_inv_q, err_inv_d;
  logic [N_LP*STATUS_W-1:0] status_q;
  logic [CW-1:0] cnt_q [N_LP];
  logic [CW-1:0] cnt_d [N_LP];
  logic full, empty, accept, lp_ok, issue, go;
  point_cmd_t din, head;
  assign din = {cmd_lp_i, cmd_obj_i, cmd_i};
  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(accept && lp_ok), .pop_i(issue),
    .data_i(din), .head_o(head), .full_o(full), .empty_o(empty)
  );
  assign cmd_ready_o = !full && !rst_i;
  assign accept = cmd_valid_i && cmd_ready_o;
  assign lp_ok = cmd_lp_i < LP_W'(N_LP);
  assign head_oh = N_LP'(1) << head.lp;
  // A reset landing on the issue cycle must swallow the pulse.
  assign issue = state_q == S_ISSUE && !rst_i;
  assign go = !empty && en_i && !(|(busy_q & head_oh));
  assign sel_o = issue ? head_oh : '0;
  assign obj_o = issue ? head.obj : '0;
  assign command_o = issue && head.cmd;
  assign busy_o = busy_q;
  assign status_o = status_q;
  assign err_invalid_o = err_inv_q;
  assign err_timeout_o = err_to_q;
  always_comb begin
    state_d = (state_q == S_IDLE && go) ? S_ISSUE : S_IDLE;
    for (int c = 0; c < N_LP; c++) begin
      busy_d[c] = busy_q[c];
      cnt_d[c] = cnt_q[c];
      to_set[c] = 1'b0;
      if (sel_o[c]) begin
        busy_d[c] = 1'b1;
        cnt_d[c] = CW'(TIMEOUT);
      end else if (busy_q[c]) begin
        cnt_d[c] = cnt_q[c] - CW'(1);
        if (done_i[c]) begin
          busy_d[c] = 1'b0;
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CW'(1)) begin
          busy_d[c] = 1'b0;
          to_set[c] = 1'b1;
        end
      end
    end
    err_to_d = (err_clr_i ? '0 : err_to_q) | to_set;
    err_inv_d = (err_inv_q && !err_clr_i) || (accept && !lp_ok);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      busy_q <= '0;
      err_to_q <= '0;
      err_inv_q <= 1'b0;
      status_q <= '0;
      cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      err_to_q <= err_to_d;
      err_inv_q <= err_inv_d;
      status_q <= ch_status_i;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_point_dispatcher.sv
// tb_point_dispatcher: directed stimulus with a queue scoreboard checked by an
// independent monitor of the select pulses.
module tb_point_dispatcher;
  logic clk = 0;
  logic rst_i, en_i, cmd_valid_i, cmd_ready_o, cmd_i, command_o, err_invalid_o, err_clr_i;
  logic [2:0] cmd_lp_i, cmd_obj_i, obj_o;
  logic [3:0] sel_o, done_i, busy_o, err_timeout_o;
  logic [19:0] ch_status_i, status_o;
  int cyc = 0, ntests = 0, nfail = 0, c, e;
  typedef struct {logic [3:0] sel; logic [2:0] obj; logic cmd; int cy;} exp_t;
  exp_t q[$];
  exp_t m_e;

  point_dispatcher dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o), .cmd_lp_i(cmd_lp_i), .cmd_obj_i(cmd_obj_i),
    .cmd_i(cmd_i), .sel_o(sel_o), .obj_o(obj_o), .command_o(command_o),
    .done_i(done_i), .ch_status_i(ch_status_i), .status_o(status_o),
    .busy_o(busy_o), .err_invalid_o(err_invalid_o),
    .err_timeout_o(err_timeout_o), .err_clr_i(err_clr_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lp, input int obj, input int cm);
    cmd_valid_i = 1;
    cmd_lp_i = 3'(lp);
    cmd_obj_i = 3'(obj);
    cmd_i = 1'(cm);
    tick();
    cmd_valid_i = 0;
  endtask

  task automatic ex(input int lp, input int obj, input int cm, input int cy);
    q.push_back('{4'(1 << lp), 3'(obj), 1'(cm), cy});
  endtask

  always @(negedge clk) begin
    if (sel_o != 0) begin
      if (q.size() == 0) chk("unexpected_pulse", {28'd0, sel_o}, 32'd0);
      else begin
        m_e = q.pop_front();
        chk("sel", {28'd0, sel_o}, {28'd0, m_e.sel});
        chk("obj", {29'd0, obj_o}, {29'd0, m_e.obj});
        chk("command", {31'd0, command_o}, {31'd0, m_e.cmd});
        if (m_e.cy >= 0) chk("issue_cycle", cyc, m_e.cy);
      end
    end
  end

  initial begin
    rst_i = 1; en_i = 1; cmd_valid_i = 0; cmd_lp_i = 0; cmd_obj_i = 0; cmd_i = 0;
    done_i = 0; err_clr_i = 0; ch_status_i = 20'h12345;
    repeat (2) tick();
    @(negedge clk);
    chk("ready_in_reset", {31'd0, cmd_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 0;
    #1;
    chk("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_busy", {28'd0, busy_o}, 32'd0);
    chk("rst_status", {12'd0, status_o}, 32'd0);
    chk("rst_err_inv", {31'd0, err_invalid_o}, 32'd0);
    chk("rst_err_to", {28'd0, err_timeout_o}, 32'd0);
    // single command latency
    c = cyc;
    ex(2, 5, 1, c + 2);
    push(2, 5, 1);
    tick();
    chk("t1_busy_k2", {28'd0, busy_o}, 32'd0);
    tick();
    chk("t1_busy_k3", {28'd0, busy_o}, 32'h4);
    done_i = 4'b0100;
    tick();
    done_i = 0;
    chk("t1_done_release", {28'd0, busy_o}, 32'd0);
    // head blocked by busy channel until timeout
    c = cyc;
    ex(1, 1, 0, c + 2);
    ex(1, 2, 1, c + 259);
    push(1, 1, 0);
    push(1, 2, 1);
    while (cyc < c + 257) tick();
    chk("t2_busy_last", {28'd0, busy_o}, 32'h2);
    chk("t2_no_err_yet", {28'd0, err_timeout_o}, 32'd0);
    tick();
    chk("t2_busy_released", {28'd0, busy_o}, 32'd0);
    chk("t2_err_timeout", {28'd0, err_timeout_o}, 32'h2);
    repeat (2) tick();
    done_i = 4'b0010;
    tick();
    done_i = 0;
    chk("t2_second_done", {28'd0, busy_o}, 32'd0);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    chk("t2_err_clr", {28'd0, err_timeout_o}, 32'd0);
    // invalid point index
    push(4, 0, 0);
    chk("t3_err_inv", {31'd0, err_invalid_o}, 32'd1);
    repeat (4) tick();
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    chk("t3_err_clr", {31'd0, err_invalid_o}, 32'd0);
    err_clr_i = 1;
    push(4, 1, 1);
    err_clr_i = 0;
    chk("t3_set_wins", {31'd0, err_invalid_o}, 32'd1);
    err_clr_i = 1;
    tick();
    err_clr_i = 0;
    chk("t3_err_clr2", {31'd0, err_invalid_o}, 32'd0);
    // fill while disabled, then drain in order
    en_i = 0;
    push(0, 3, 0);
    push(1, 4, 1);
    push(2, 5, 0);
    chk("t4_ready_3", {31'd0, cmd_ready_o}, 32'd1);
    push(3, 6, 1);
    chk("t4_ready_full", {31'd0, cmd_ready_o}, 32'd0);
    push(0, 7, 1);
    chk("t4_ready_still_full", {31'd0, cmd_ready_o}, 32'd0);
    e = cyc;
    ex(0, 3, 0, e + 1);
    ex(1, 4, 1, e + 3);
    ex(2, 5, 0, e + 5);
    ex(3, 6, 1, e + 7);
    en_i = 1;
    repeat (8) tick();
    chk("t4_busy_all", {28'd0, busy_o}, 32'hF);
    chk("t4_ready_empty", {31'd0, cmd_ready_o}, 32'd1);
    done_i = 4'hF;
    tick();
    done_i = 0;
    chk("t4_release_all", {28'd0, busy_o}, 32'd0);
    // done on the same edge the timeout expires
    c = cyc;
    ex(0, 1, 1, c + 2);
    push(0, 1, 1);
    while (cyc < c + 257) tick();
    chk("t5_busy_last", {28'd0, busy_o}, 32'h1);
    done_i = 4'b0001;
    tick();
    done_i = 0;
    chk("t5_busy", {28'd0, busy_o}, 32'd0);
    chk("t5_no_timeout", {28'd0, err_timeout_o}, 32'd0);
    // reset landing on the issue cycle
    en_i = 0;
    push(0, 1, 0);
    push(1, 2, 0);
    push(2, 3, 0);
    en_i = 1;
    tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    chk("t6_busy", {28'd0, busy_o}, 32'd0);
    chk("t6_ready", {31'd0, cmd_ready_o}, 32'd1);
    repeat (4) tick();
    chk("t6_busy_after", {28'd0, busy_o}, 32'd0);
    chk("t6_status_old", {12'd0, status_o}, 32'h12345);
    ch_status_i = 20'hABCDE;
    tick();
    chk("t6_status", {12'd0, status_o}, 32'hABCDE);
    chk("sb_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/point_dispatcher.md
Name: point_dispatcher

Overview:
- Parametrised command dispatcher for a bank of N_LP linear_point channels.
- Accepts (point, object, command) requests over a valid/ready interface and buffers them in order in a FIFO.
- Issues each request as a one-cycle one-hot select pulse, but only when the target channel is not busy.
- Tracks per-channel completion or timeout; registers the concatenated channel status and reports sticky errors.

Parameters:
- N_LP, 4, number of linear_point channels.
- OBJ_W, 3, object number width.
- STATUS_W, 5, status width per channel.
- DEPTH, 4, command FIFO depth (power of two, >=2).
- TIMEOUT, 255, cycles a channel may stay busy before forced release.
- LP_W, $clog2(N_LP+1), point index width, so out-of-range indices are representable.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  1  dispatch enable; when low, commands are still queued but none are issued.
- cmd_valid_i  in  1  request valid.
- cmd_ready_o  out  1  FIFO not full.
- cmd_lp_i  in  LP_W  target point index.
- cmd_obj_i  in  OBJ_W  object number.
- cmd_i  in  1  command bit.
- sel_o  out  N_LP  one-hot issue pulse.
- obj_o  out  OBJ_W  object number for the issued command; valid while sel_o != 0.
- command_o  out  1  command bit for the issued command; valid while sel_o != 0.
- done_i  in  N_LP  per-channel completion pulse.
- ch_status_i  in  N_LP*STATUS_W  raw channel status.
- status_o  out  N_LP*STATUS_W  registered ch_status_i.
- busy_o  out  N_LP  channel has a command in flight.
- err_invalid_o  out  1  sticky: a request with cmd_lp_i >= N_LP was dropped.
- err_timeout_o  out  N_LP  sticky per-channel timeout.
- err_clr_i  in  1  clears all sticky errors.

Behaviour:
- Reset values (next edge with rst_i high):
  - FIFO flushed.
  - sel_o, obj_o, command_o, busy_o, status_o, err_* = 0.
  - All timeout counters = 0; FSM = S_IDLE.
  - cmd_ready_o = 0 while rst_i is high, 1 in the first cycle after.
  - Reset mid-issue suppresses the pending pulse.
- Acceptance:
  - A request is accepted on an edge where cmd_valid_i && cmd_ready_o.
  - Valid lp (< N_LP): written to the FIFO.
  - Invalid lp: discarded, err_invalid_o set on the same edge; it never enters the FIFO.
- FSM states:
  - S_IDLE: if FIFO non-empty && en_i && !busy_o[head.lp], go to S_ISSUE.
    - Otherwise remain in S_IDLE. The head blocks the queue (strict in-order, no bypass).
  - S_ISSUE: exactly one cycle.
    - sel_o = 1<<head.lp, obj_o = head.obj, command_o = head.cmd.
    - FIFO popped; busy_o[lp] set; counter[lp] loaded with TIMEOUT. Return to S_IDLE.
  - en_i dropping while in S_ISSUE does not cancel the pulse already committed.
- Timing:
  - Latency: request accepted in cycle k → sel_o high in cycle k+2 at the earliest.
  - Peak throughput: one issue per 2 cycles.
- Busy release:
  - done_i[c] with busy_o[c]=1 clears busy_o[c] on that edge.
  - done_i[c] with busy_o[c]=0 is ignored.
  - Counter decrements each cycle while busy. On reaching 0 with no done: busy cleared, err_timeout_o[c] set.
  - done and the timeout expiring on the same edge: treated as done, no error.
  - The issue decision uses registered busy_o, so a channel freed by done on edge e can be reissued no earlier than S_ISSUE in cycle e+1.
- Simultaneous FIFO events:
  - Push and pop on the same edge is allowed when full.
  - cmd_ready_o is the registered not-full state; a simultaneous pop does not assert ready in that cycle.
- Errors:
  - err_clr_i clears all sticky bits.
  - A set and a clear on the same edge: set wins.
- status_o = ch_status_i delayed by one cycle; it is not gated by busy.

Decomposition:
- Package point_pkg:
  - typedef struct packed {lp, obj, cmd} point_cmd_t.
  - enum {S_IDLE, S_ISSUE} disp_state_t.
  - Default localparams for N_LP, OBJ_W, STATUS_W.
- Sub-module cmd_fifo:
  - Parametrised synchronous FIFO of point_cmd_t.
  - Ports: push, pop, full, empty, head data.
  - Pointer wrap uses an extra MSB.

Test Plan:
- Reset, then push {lp=2, obj=5, cmd=1} at cycle k → sel_o=4'b0100, obj_o=5, command_o=1 in cycle k+2 only; busy_o=4'b0100 from cycle k+3.
- Push lp=1 twice, with no done → first issues; second holds the head for TIMEOUT=255 cycles, then err_timeout_o[1]=1 and the second issues 2 cycles after release.
- Push lp=4 (invalid, N_LP=4) → no sel_o pulse, err_invalid_o=1, FIFO stays empty; err_clr_i pulse → err_invalid_o=0.
- en_i=0, push 5 commands to distinct free channels → cmd_ready_o=0 after the 4th; raise en_i → 4 pulses 2 cycles apart in push order.
- done_i[0] and counter[0] expiring on the same edge → busy_o[0]=0, err_timeout_o[0]=0.
- rst_i during S_ISSUE with 3 entries queued → no pulse, FIFO empty, busy_o=0; ch_status_i=20'hABCDE → status_o=20'hABCDE one cycle later.
